// File: rtl/wide_add_pkg.sv
// Shared types and constants for the limb-serial wide adder.
package wide_add_pkg;

    localparam int unsigned LIMB_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wa_state_t;

endpackage

// File: rtl/wide_add_seq_fa32.sv
// 32-bit full adder used as the per-limb datapath of wide_add_seq.
module FullAdder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = 33'(a) + 33'(b) + 33'(cin);

endmodule

// File: rtl/wide_add_seq.sv
// Arbitrary-width adder: streams a LIMBS x 32-bit operand pair through one
// FullAdder32, least-significant limb first, with the carry registered between limbs.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned LIMBS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*LIMBS-1:0] a,
    input  logic [LIMB_W*LIMBS-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*LIMBS-1:0] sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int unsigned W     = LIMB_W * LIMBS;
    localparam int unsigned CNT_W = $clog2(LIMBS);

    wa_state_t          state_q, state_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               last_limb;
    logic [LIMB_W-1:0]  fa_sum;
    logic               fa_cout;

    // in_ready is the only input-to-output combinational path (via out_ready).
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_limb = (cnt_q == CNT_W'(LIMBS - 1));

    assign busy      = (state_q == RUN);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    FullAdder32 u_fa (
        .a    (op_a_q[LIMB_W-1:0]),
        .b    (op_b_q[LIMB_W-1:0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE goes straight to RUN when a new pair is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_limb) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-values.
    always_comb begin
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        case (state_q)
            RUN: begin
                for (int k = 0; k < int'(LIMBS); k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*LIMB_W +: LIMB_W] = fa_sum;
                    end
                end
                carry_d = fa_cout;
                op_a_d  = op_a_q >> LIMB_W;
                op_b_d  = op_b_q >> LIMB_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_limb) begin
                    out_valid_d = 1'b1;
                    cout_d      = fa_cout;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            op_a_d  = a;
            op_b_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random checks of wide_add_seq at LIMBS=4 and LIMBS=2, with a
// scoreboard of expected {cout, sum} values.
module tb_wide_add_seq;

    logic         clk;
    logic         rst_n;

    logic         in_valid, in_ready, cin_4, out_valid, out_ready, cout_4, busy;
    logic [127:0] a_4, b_4, sum_4;

    logic         in_valid2, in_ready2, cin_2, out_valid2, out_ready2, cout_2, busy2;
    logic [63:0]  a_2, b_2, sum_2;

    int           n_tests;
    int           n_fail;
    logic [128:0] sb[$];

    wide_add_seq #(.LIMBS(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a_4), .b(b_4), .cin(cin_4),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum_4), .cout(cout_4), .busy(busy)
    );

    wide_add_seq #(.LIMBS(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a_2), .b(b_2), .cin(cin_2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum_2), .cout(cout_2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] model4(input logic [127:0] x, input logic [127:0] y,
                                            input logic c);
        return 129'(x) + 129'(y) + 129'(c);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one pair at a negedge; returns at the negedge after the accept edge.
    task automatic send4(input logic [127:0] x, input logic [127:0] y, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        a_4      = x;
        b_4      = y;
        cin_4    = c;
        #1;
        chk("send_in_ready", in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(model4(x, y, c));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out4(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic pop_chk4(input string tag);
        logic [128:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk(tag, {cout_4, sum_4}, e);
    endtask

    task automatic drain4();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int           lat;
        int           acc, got, cyc, quiet_bad;
        int           acc_cyc[$];
        logic [128:0] held;
        logic [127:0] xa, xb;

        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_4 = '0; b_4 = '0; cin_4 = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a_2 = '0; b_2 = '0; cin_2 = 1'b0;

        // Reset values
        #22;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sum", sum_4, 128'h0);
        chk("rst_cout", cout_4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry ripple across all limbs
        send4({128{1'b1}}, 128'h1, 1'b0);
        chk("t1_busy", busy, 1'b1);
        wait_out4(lat);
        chk("t1_latency", lat, 4);
        chk("t1_result", {cout_4, sum_4}, {1'b1, 128'h0});
        pop_chk4("t1_sb");
        drain4();

        // Carry-in only
        send4(128'h0, 128'h0, 1'b1);
        wait_out4(lat);
        chk("t2_result", {cout_4, sum_4}, {1'b0, 128'h1});
        pop_chk4("t2_sb");
        drain4();

        // Backpressure: result holds, new operands refused until out_ready
        send4(rnd128(), rnd128(), 1'b1);
        wait_out4(lat);
        held = (sb.size() > 0) ? sb[0] : 'x;
        pop_chk4("t3_first");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a_4 = rnd128();
            b_4 = rnd128();
            cin_4 = 1'b1;
            #1;
            chk("t3_in_ready_low", in_ready, 1'b0);
            chk("t3_held", {cout_4, sum_4}, held);
            chk("t3_out_valid_held", out_valid, 1'b1);
        end
        xa = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        xb = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        @(negedge clk);
        a_4 = xa; b_4 = xb; cin_4 = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready_release", in_ready, 1'b1);
        @(posedge clk);
        sb.push_back(model4(xa, xb, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t3_out_valid_drop", out_valid, 1'b0);
        wait_out4(lat);
        chk("t3_latency", lat, 4);
        pop_chk4("t3_second");
        drain4();

        // Back-to-back with out_ready high; random pairs against the model
        out_ready = 1'b1;
        acc = 0; got = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                pop_chk4("t4_result");
                chk("t4_latency", cyc - ((acc_cyc.size() > 0) ? acc_cyc.pop_front() : 0), 5);
                got++;
            end
            if (acc < 1000) begin
                in_valid = 1'b1;
                a_4 = (acc % 9 == 0) ? {128{1'b1}} : rnd128();
                b_4 = (acc % 13 == 0) ? 128'h1 : rnd128();
                cin_4 = 1'($urandom_range(0, 1));
                #1;
                if (in_ready === 1'b1) begin
                    sb.push_back(model4(a_4, b_4, cin_4));
                    acc_cyc.push_back(cyc);
                    acc++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("t4_count", got, 1000);
        chk("t4_sb_empty", sb.size(), 0);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN
        send4(rnd128(), rnd128(), 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_sum", sum_4, 128'h0);
        chk("t5_cout", cout_4, 1'b0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) quiet_bad++;
        end
        chk("t5_no_out_valid", quiet_bad, 0);
        chk("t5_in_ready_after", in_ready, 1'b1);

        // Minimum limb count
        @(negedge clk);
        in_valid2 = 1'b1;
        a_2 = 64'hFFFF_FFFF_0000_0000;
        b_2 = 64'h0000_0001_0000_0000;
        cin_2 = 1'b0;
        #1;
        chk("t6_in_ready", in_ready2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_latency", lat, 2);
        chk("t6_result", {cout_2, sum_2}, {1'b1, 64'h0});
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        xa[63:0] = {$urandom, $urandom};
        xb[63:0] = {$urandom, $urandom};
        in_valid2 = 1'b1;
        a_2 = xa[63:0];
        b_2 = xb[63:0];
        cin_2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_rand_latency", lat, 2);
        chk("t6_rand_result", {cout_2, sum_2}, 65'(xa[63:0]) + 65'(xb[63:0]) + 65'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
